// File: rtl/exec_pkg.sv
// Shared constants for the RV64 execute stage: ALUOp classes, funct3 codes
// and the 4-bit ALU operation encodings.
package exec_pkg;

    localparam logic [1:0] ALUOP_MEM = 2'b00;
    localparam logic [1:0] ALUOP_BR  = 2'b01;
    localparam logic [1:0] ALUOP_R   = 2'b10;

    localparam logic [2:0] F3_ADD_SUB = 3'b000;
    localparam logic [2:0] F3_SLT     = 3'b010;
    localparam logic [2:0] F3_XOR     = 3'b100;
    localparam logic [2:0] F3_OR      = 3'b110;
    localparam logic [2:0] F3_AND     = 3'b111;

    typedef enum logic [3:0] {
        OP_AND = 4'b0000,
        OP_OR  = 4'b0001,
        OP_ADD = 4'b0010,
        OP_XOR = 4'b0011,
        OP_SUB = 4'b0110,
        OP_SLT = 4'b0111,
        OP_NOR = 4'b1100
    } alu_oper_e;

endpackage

// File: rtl/exec_alu_core.sv
// Purely combinational XLEN-wide ALU with zero flag; unknown encodings yield 0.
module exec_alu_core
    import exec_pkg::*;
#(
    parameter int XLEN = 64
) (
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    input  logic [3:0]      operation,
    output logic [XLEN-1:0] result,
    output logic            zero
);

    logic slt_s;

    // Signed less-than, the only operation that needs a signed view of the operands
    always_comb begin
        slt_s = 1'b0;
        if ($signed(a) < $signed(b)) begin
            slt_s = 1'b1;
        end else begin
            slt_s = 1'b0;
        end
    end

    // Operation select
    always_comb begin
        result = {XLEN{1'b0}};
        case (operation)
            OP_AND:  result = a & b;
            OP_OR:   result = a | b;
            OP_XOR:  result = a ^ b;
            OP_ADD:  result = a + b;
            OP_SUB:  result = a - b;
            OP_SLT:  result = {{(XLEN-1){1'b0}}, slt_s};
            OP_NOR:  result = ~(a | b);
            default: result = {XLEN{1'b0}};
        endcase
    end

    // Zero flag derived from the same cycle's result
    always_comb begin
        zero = 1'b0;
        if (result == {XLEN{1'b0}}) begin
            zero = 1'b1;
        end else begin
            zero = 1'b0;
        end
    end

endmodule

// File: rtl/exec_unit.sv
// Execute stage: ALU-control decode, 64-bit ALU and branch-target adder,
// with every output registered one cycle after the sampling edge.
module exec_unit
    import exec_pkg::*;
#(
    parameter int XLEN = 64,
    parameter int PC_W = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    input  logic [1:0]      alu_op,
    input  logic            funct7_b30,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] op_a,
    input  logic [XLEN-1:0] op_b,
    input  logic [PC_W-1:0] pc,
    input  logic [XLEN-1:0] br_offset,
    output logic            out_valid,
    output logic [3:0]      operation,
    output logic [XLEN-1:0] result,
    output logic            zero,
    output logic [XLEN-1:0] br_target
);

    alu_oper_e       op_s;
    logic [XLEN-1:0] alu_result_s;
    logic            alu_zero_s;
    logic [XLEN-1:0] br_target_s;

    logic            out_valid_r;
    logic [3:0]      operation_r;
    logic [XLEN-1:0] result_r;
    logic            zero_r;
    logic [XLEN-1:0] br_target_r;

    // ALU-control decode from ALUOp and the R-type function fields
    always_comb begin
        op_s = OP_ADD;
        case (alu_op)
            ALUOP_MEM: op_s = OP_ADD;
            ALUOP_BR:  op_s = OP_SUB;
            ALUOP_R: begin
                case (funct3)
                    F3_ADD_SUB: begin
                        if (funct7_b30) begin
                            op_s = OP_SUB;
                        end else begin
                            op_s = OP_ADD;
                        end
                    end
                    F3_AND:  op_s = OP_AND;
                    F3_OR:   op_s = OP_OR;
                    F3_XOR:  op_s = OP_XOR;
                    F3_SLT:  op_s = OP_SLT;
                    default: op_s = OP_ADD;
                endcase
            end
            default:   op_s = OP_ADD;
        endcase
    end

    exec_alu_core #(
        .XLEN (XLEN)
    ) u_alu (
        .a         (op_a),
        .b         (op_b),
        .operation (op_s),
        .result    (alu_result_s),
        .zero      (alu_zero_s)
    );

    // Branch target: PC is zero-extended so the sum is never truncated to PC_W
    always_comb begin
        br_target_s = {{(XLEN-PC_W){1'b0}}, pc} + br_offset;
    end

    // Output registers; data holds while no valid sample is presented
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_r <= 1'b0;
            operation_r <= 4'b0000;
            result_r    <= {XLEN{1'b0}};
            zero_r      <= 1'b0;
            br_target_r <= {XLEN{1'b0}};
        end else begin
            out_valid_r <= in_valid;
            if (in_valid) begin
                operation_r <= op_s;
                result_r    <= alu_result_s;
                zero_r      <= alu_zero_s;
                br_target_r <= br_target_s;
            end
        end
    end

    assign out_valid = out_valid_r;
    assign operation = operation_r;
    assign result    = result_r;
    assign zero      = zero_r;
    assign br_target = br_target_r;

endmodule

// File: tb/tb_exec_unit.sv
// Self-checking bench for exec_unit: directed literal cases plus randomized
// traffic compared every cycle against a behavioural reference model.
module tb_exec_unit;

    localparam int XLEN = 64;
    localparam int PC_W = 32;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            in_valid = 1'b0;
    logic [1:0]      alu_op = 2'b00;
    logic            funct7_b30 = 1'b0;
    logic [2:0]      funct3 = 3'b000;
    logic [XLEN-1:0] op_a = 64'd0;
    logic [XLEN-1:0] op_b = 64'd0;
    logic [PC_W-1:0] pc = 32'd0;
    logic [XLEN-1:0] br_offset = 64'd0;
    logic            out_valid;
    logic [3:0]      operation;
    logic [XLEN-1:0] result;
    logic            zero;
    logic [XLEN-1:0] br_target;

    int checks = 0;
    int errors = 0;

    exec_unit #(.XLEN(XLEN), .PC_W(PC_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .alu_op     (alu_op),
        .funct7_b30 (funct7_b30),
        .funct3     (funct3),
        .op_a       (op_a),
        .op_b       (op_b),
        .pc         (pc),
        .br_offset  (br_offset),
        .out_valid  (out_valid),
        .operation  (operation),
        .result     (result),
        .zero       (zero),
        .br_target  (br_target)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: the instruction semantics computed directly
    function automatic logic [63:0] ref_result(input logic [1:0] aop, input logic b30,
                                               input logic [2:0] f3, input logic [63:0] a,
                                               input logic [63:0] b);
        longint sa;
        longint sb;
        sa = a;
        sb = b;
        if (aop == 2'b01) return a - b;
        if (aop != 2'b10) return a + b;
        if (f3 == 3'b000) return b30 ? (a - b) : (a + b);
        if (f3 == 3'b111) return a & b;
        if (f3 == 3'b110) return a | b;
        if (f3 == 3'b100) return a ^ b;
        if (f3 == 3'b010) return (sa < sb) ? 64'd1 : 64'd0;
        return a + b;
    endfunction

    function automatic logic [3:0] ref_op(input logic [1:0] aop, input logic b30,
                                          input logic [2:0] f3);
        if (aop == 2'b01) return 4'b0110;
        if (aop != 2'b10) return 4'b0010;
        if (f3 == 3'b000) return b30 ? 4'b0110 : 4'b0010;
        if (f3 == 3'b111) return 4'b0000;
        if (f3 == 3'b110) return 4'b0001;
        if (f3 == 3'b100) return 4'b0011;
        if (f3 == 3'b010) return 4'b0111;
        return 4'b0010;
    endfunction

    logic        exp_valid = 1'b0;
    logic [3:0]  exp_op = 4'd0;
    logic [63:0] exp_res = 64'd0;
    logic        exp_zero = 1'b0;
    logic [63:0] exp_bt = 64'd0;
    logic        cmp_en = 1'b0;

    always @(posedge clk) begin
        if (rst) begin
            exp_valid <= 1'b0;
            exp_op    <= 4'd0;
            exp_res   <= 64'd0;
            exp_zero  <= 1'b0;
            exp_bt    <= 64'd0;
        end else begin
            exp_valid <= in_valid;
            if (in_valid) begin
                exp_op   <= ref_op(alu_op, funct7_b30, funct3);
                exp_res  <= ref_result(alu_op, funct7_b30, funct3, op_a, op_b);
                exp_zero <= (ref_result(alu_op, funct7_b30, funct3, op_a, op_b) == 64'd0);
                exp_bt   <= 64'(pc) + br_offset;
            end
        end
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            check("m_valid", 64'(out_valid), 64'(exp_valid));
            check("m_operation", 64'(operation), 64'(exp_op));
            check("m_result", result, exp_res);
            check("m_zero", 64'(zero), 64'(exp_zero));
            check("m_br_target", br_target, exp_bt);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic apply(input logic v, input logic [1:0] aop, input logic b30,
                         input logic [2:0] f3, input logic [63:0] a, input logic [63:0] b,
                         input logic [31:0] p, input logic [63:0] off);
        in_valid = v; alu_op = aop; funct7_b30 = b30; funct3 = f3;
        op_a = a; op_b = b; pc = p; br_offset = off;
        step();
    endtask

    task automatic lit(input string name, input logic [3:0] op, input logic [63:0] res,
                       input logic z);
        check({name, "_valid"}, 64'(out_valid), 64'd1);
        check({name, "_op"}, 64'(operation), 64'(op));
        check({name, "_res"}, result, res);
        check({name, "_zero"}, 64'(zero), 64'(z));
    endtask

    function automatic logic [63:0] pick();
        case ($urandom_range(0, 5))
            0:       return 64'd0;
            1:       return 64'hFFFF_FFFF_FFFF_FFFF;
            2:       return 64'h8000_0000_0000_0000;
            3:       return 64'(int'($urandom_range(0, 15)) - 8);
            default: return {$urandom(), $urandom()};
        endcase
    endfunction

    initial begin
        logic [63:0] a;
        logic [63:0] f0;
        logic [63:0] res_hold;
        cmp_en = 1'b1;
        // Reset with valid, nonzero inputs
        rst = 1'b1;
        apply(1'b1, 2'b10, 1'b0, 3'b110, 64'h55, 64'hAA, 32'h100, 64'h40);
        step();
        check("rst_valid", 64'(out_valid), 64'd0);
        check("rst_res", result, 64'd0);
        check("rst_bt", br_target, 64'd0);
        check("rst_op", 64'(operation), 64'd0);
        rst = 1'b0;
        apply(1'b1, 2'b00, 1'b0, 3'b000, 64'h10, 64'h8, 32'h100, 64'h10);
        lit("ldst", 4'b0010, 64'h18, 1'b0);
        check("bt_fwd", br_target, 64'h110);

        apply(1'b1, 2'b01, 1'b0, 3'b000, 64'h1234, 64'h1234, 32'h100, 64'hFFFF_FFFF_FFFF_FFF8);
        lit("beq_eq", 4'b0110, 64'd0, 1'b1);
        check("bt_neg", br_target, 64'hF8);
        apply(1'b1, 2'b01, 1'b0, 3'b000, 64'h1234, 64'h1235, 32'hFFFF_FFFC, 64'h8);
        lit("beq_ne", 4'b0110, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0);
        check("bt_wide", br_target, 64'h1_0000_0004);

        apply(1'b1, 2'b10, 1'b0, 3'b000, 64'hF0, 64'h3C, 32'h0, 64'h0);
        lit("r_add", 4'b0010, 64'h12C, 1'b0);
        apply(1'b1, 2'b10, 1'b1, 3'b000, 64'hF0, 64'h3C, 32'h0, 64'h0);
        lit("r_sub", 4'b0110, 64'hB4, 1'b0);
        apply(1'b1, 2'b10, 1'b0, 3'b111, 64'hF0, 64'h3C, 32'h0, 64'h0);
        lit("r_and", 4'b0000, 64'h30, 1'b0);
        apply(1'b1, 2'b10, 1'b0, 3'b110, 64'hF0, 64'h3C, 32'h0, 64'h0);
        lit("r_or", 4'b0001, 64'hFC, 1'b0);
        apply(1'b1, 2'b10, 1'b0, 3'b100, 64'hF0, 64'h3C, 32'h0, 64'h0);
        lit("r_xor", 4'b0011, 64'hCC, 1'b0);
        apply(1'b1, 2'b10, 1'b0, 3'b010, 64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 32'h0, 64'h0);
        lit("r_slt", 4'b0111, 64'h1, 1'b0);
        apply(1'b1, 2'b10, 1'b0, 3'b010, 64'h1, 64'hFFFF_FFFF_FFFF_FFFF, 32'h0, 64'h0);
        lit("r_slt_n", 4'b0111, 64'h0, 1'b1);
        apply(1'b1, 2'b10, 1'b1, 3'b001, 64'h5, 64'h3, 32'h0, 64'h0);
        lit("r_other", 4'b0010, 64'h8, 1'b0);
        apply(1'b1, 2'b11, 1'b1, 3'b111, 64'h5, 64'h3, 32'h0, 64'h0);
        lit("aop11", 4'b0010, 64'h8, 1'b0);

        apply(1'b1, 2'b00, 1'b0, 3'b000, 64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 32'h20, 64'h4);
        lit("add_ovf", 4'b0010, 64'd0, 1'b1);
        apply(1'b0, 2'b01, 1'b0, 3'b000, 64'h9, 64'h2, 32'h7, 64'h7);
        check("hold_valid", 64'(out_valid), 64'd0);
        check("hold_res", result, 64'd0);
        check("hold_zero", 64'(zero), 64'd1);
        check("hold_bt", br_target, 64'h24);

        // Reset mid-stream discards the in-flight sample
        apply(1'b1, 2'b00, 1'b0, 3'b000, 64'h3, 64'h4, 32'h0, 64'h0);
        rst = 1'b1;
        apply(1'b1, 2'b00, 1'b0, 3'b000, 64'h30, 64'h40, 32'h0, 64'h0);
        check("mid_rst_valid", 64'(out_valid), 64'd0);
        check("mid_rst_res", result, 64'd0);
        rst = 1'b0;
        apply(1'b0, 2'b00, 1'b0, 3'b000, 64'h1, 64'h1, 32'h0, 64'h0);
        check("post_rst_res", result, 64'd0);

        // Randomized traffic, checked by the model on every cycle
        for (int i = 0; i < 600; i++) begin
            rst = ($urandom_range(0, 59) == 0);
            a = pick();
            f0 = ($urandom_range(0, 3) == 0) ? a : pick();
            apply($urandom_range(0, 4) != 0, 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                  3'($urandom_range(0, 7)), a, f0, $urandom(), pick());
        end
        rst = 1'b0;
        apply(1'b0, 2'b00, 1'b0, 3'b000, 64'h0, 64'h0, 32'h0, 64'h0);
        res_hold = result;
        apply(1'b0, 2'b01, 1'b0, 3'b000, 64'h7, 64'h1, 32'h0, 64'h0);
        check("final_hold", result, res_hold);
        @(negedge clk);
        cmp_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
